multicycle_control_unit: RTL and testbench

Multicycle control FSM for the RV32 subset core (lw, sw, beq, add, sub, or, and, plus addi when enabled). It sequences each instruction through fetch, decode, execute, memory and writeback, and waits on a memory ready handshake. It keeps a retired-instruction counter and traps illegal opcodes and memory timeouts. It sits between the instruction register and the datapath enables (PC, IR, register file, ALU, data memory) and drives the same ALUOP encoding as the single-cycle unit.

---
 rtl/multicycle_control_unit_if.sv | 33 +++
 rtl/multicycle_control_unit.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multicycle control FSM and the RV32-subset datapath.
// master = control unit (drives enables), slave = datapath (drives instruction, flags, memory ready).
interface multicycle_control_unit_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instruction;
  logic             zero;
  logic             mem_ready;
  logic [3:0]       aluop;
  logic             pcsrc;
  logic             pcwrite;
  logic             irwrite;
  logic             alusrc;
  logic             memtoread;
  logic             memwrite;
  logic             memtoreg;
  logic             regwrite;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  instruction, zero, mem_ready,
    output aluop, pcsrc, pcwrite, irwrite, alusrc, memtoread, memwrite,
           memtoreg, regwrite, illegal, state, instr_count
  );

  modport slave (
    output instruction, zero, mem_ready,
    input  aluop, pcsrc, pcwrite, irwrite, alusrc, memtoread, memwrite,
           memtoreg, regwrite, illegal, state, instr_count
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32-subset control FSM (3-5 cycles/instr) with retire counter and illegal/timeout trap.
// Enables are combinational from state and inputs; FETCH/MEM stall on mem_ready low, trapping after MEM_TIMEOUT low cycles.
module multicycle_control_unit #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter bit EN_ADDI     = 1'b1
) (
  input logic                       clk,
  input logic                       rst,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM    = 4'd4,
    S_EXEC   = 4'd5,
    S_WB     = 4'd6,
    S_BRANCH = 4'd7,
    S_TRAP   = 4'd8
  } state_t;

  localparam int         WW        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_NONE  = 4'b1111;

  state_t           state_q, state_nxt;
  logic [WW-1:0]    wait_q;
  logic [CNT_W-1:0] cnt_q;
  logic             illegal_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       is_load, is_addi, rtype_ok, addi_ok;
  logic       mem_state, timeout, retire;
  logic [3:0] exec_op;

  assign opcode    = bus.instruction[6:0];
  assign funct3    = bus.instruction[14:12];
  assign funct7b5  = bus.instruction[30];
  assign is_load   = (opcode == OP_LOAD);
  assign is_addi   = (opcode == OP_ITYPE);
  assign rtype_ok  = (opcode == OP_RTYPE) &&
                     ((funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111));
  assign addi_ok   = EN_ADDI && is_addi && (funct3 == 3'b000);
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM);

  // Fires on the low cycle that would bring the wait count up to the limit; ready that cycle wins.
  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      assign timeout = mem_state && !bus.mem_ready && (wait_q == WW'(MEM_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

  always_comb begin
    exec_op = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      case (funct3)
        3'b000:  exec_op = funct7b5 ? ALU_SUB : ALU_ADD;
        3'b110:  exec_op = ALU_OR;
        3'b111:  exec_op = ALU_AND;
        default: exec_op = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state_q;
    bus.aluop     = ALU_NONE;
    bus.pcsrc     = 1'b0;
    bus.pcwrite   = 1'b0;
    bus.irwrite   = 1'b0;
    bus.alusrc    = 1'b0;
    bus.memtoread = 1'b0;
    bus.memwrite  = 1'b0;
    bus.memtoreg  = 1'b0;
    bus.regwrite  = 1'b0;
    case (state_q)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        bus.memtoread = !timeout;
        if (bus.mem_ready) begin
          bus.irwrite = 1'b1;
          bus.pcwrite = 1'b1;
          state_nxt   = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_TRAP;
        end
      end
      S_DECODE: begin
        if (opcode == OP_BRANCH)                         state_nxt = S_BRANCH;
        else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) state_nxt = S_ADDR;
        else if (rtype_ok || addi_ok)                    state_nxt = S_EXEC;
        else                                             state_nxt = S_TRAP;
      end
      S_ADDR: begin
        bus.alusrc = 1'b1;
        bus.aluop  = ALU_ADD;
        state_nxt  = S_MEM;
      end
      S_MEM: begin
        bus.aluop     = ALU_AND;
        bus.memtoread = is_load && !timeout;
        bus.memwrite  = !is_load && !timeout;
        if (bus.mem_ready)  state_nxt = is_load ? S_WB : S_FETCH;
        else if (timeout)   state_nxt = S_TRAP;
      end
      S_EXEC: begin
        bus.alusrc = is_addi;
        bus.aluop  = exec_op;
        state_nxt  = S_WB;
      end
      S_WB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = is_load;
        state_nxt    = S_FETCH;
      end
      S_BRANCH: begin
        bus.aluop = ALU_SUB;
        if (bus.zero) begin
          bus.pcwrite = 1'b1;
          bus.pcsrc   = 1'b1;
        end
        state_nxt = S_FETCH;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Every path back to FETCH from WB, BRANCH or MEM completes an instruction.
  assign retire = (state_nxt == S_FETCH) &&
                  ((state_q == S_WB) || (state_q == S_BRANCH) || (state_q == S_MEM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if ((state_nxt != state_q) && ((state_nxt == S_FETCH) || (state_nxt == S_MEM)))
        wait_q <= '0;
      else if (mem_state && !bus.mem_ready)
        wait_q <= wait_q + 1'b1;
      if (retire)
        cnt_q <= cnt_q + 1'b1;
      if (state_nxt == S_TRAP)
        illegal_q <= 1'b1;
    end
  end

  assign bus.illegal     = illegal_q;
  assign bus.state       = state_q;
  assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboarded bench: per-cycle expected state/enables queued as inputs are driven, compared at the falling edge.
module tb_multicycle_control_unit;
  localparam logic [3:0] S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4;
  localparam logic [3:0] S5 = 4'd5, S6 = 4'd6, S7 = 4'd7, S8 = 4'd8;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110, OP_NONE = 4'b1111;
  localparam logic [8:0] C_NONE = 9'h000, C_PCSRC = 9'h100, C_PCWR = 9'h080, C_IRWR = 9'h040;
  localparam logic [8:0] C_ASRC = 9'h020, C_MRD = 9'h010, C_MWR = 9'h008, C_M2R = 9'h004;
  localparam logic [8:0] C_RW = 9'h002, C_ILL = 9'h001;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_SLL  = 32'h002091B3;
  localparam logic [31:0] I_ADDI = 32'h00508193;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;

  typedef struct {
    string      tag;
    logic       sel;
    logic [3:0] st;
    logic [3:0] op;
    logic       op_chk;
    logic [8:0] ctl;
  } exp_t;

  exp_t  exp_q[$];
  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  sel_b = 1'b0;
  string cur_tag = "reset";
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.CNT_W(16)) mif_a ();
  multicycle_control_unit_if #(.CNT_W(4))  mif_b ();

  multicycle_control_unit #(.CNT_W(16), .MEM_TIMEOUT(15), .EN_ADDI(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(mif_a)
  );
  multicycle_control_unit #(.CNT_W(4), .MEM_TIMEOUT(0), .EN_ADDI(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(mif_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [3:0] s, o;
      logic [8:0] c;
      e = exp_q.pop_front();
      if (e.sel) begin
        s = mif_b.state; o = mif_b.aluop;
        c = {mif_b.pcsrc, mif_b.pcwrite, mif_b.irwrite, mif_b.alusrc, mif_b.memtoread,
             mif_b.memwrite, mif_b.memtoreg, mif_b.regwrite, mif_b.illegal};
      end else begin
        s = mif_a.state; o = mif_a.aluop;
        c = {mif_a.pcsrc, mif_a.pcwrite, mif_a.irwrite, mif_a.alusrc, mif_a.memtoread,
             mif_a.memwrite, mif_a.memtoreg, mif_a.regwrite, mif_a.illegal};
      end
      check({e.tag, " state"}, 32'(s), 32'(e.st));
      check({e.tag, " ctl"}, 32'(c), 32'(e.ctl));
      if (e.op_chk) check({e.tag, " aluop"}, 32'(o), 32'(e.op));
    end
  end

  // One clock cycle: drive inputs, queue what the selected DUT must show during this cycle.
  task automatic cyc(input logic [3:0] st, input logic [3:0] op, input logic op_chk,
                     input logic [8:0] ctl, input logic rdy, input logic z);
    exp_t e;
    mif_a.mem_ready = rdy; mif_b.mem_ready = rdy;
    mif_a.zero = z;        mif_b.zero = z;
    e.tag = cur_tag; e.sel = sel_b; e.st = st; e.op = op; e.op_chk = op_chk; e.ctl = ctl;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input string t, input logic [31:0] ins);
    cur_tag = t;
    mif_a.instruction = ins;
    mif_b.instruction = ins;
  endtask

  task automatic do_reset();
    cur_tag = "reset";
    rst = 1'b1;
    cyc(S0, OP_NONE, 1'b1, C_NONE, rnd(), rnd());
    cyc(S0, OP_NONE, 1'b1, C_NONE, rnd(), rnd());
    rst = 1'b0;
    cyc(S0, OP_NONE, 1'b1, C_NONE, rnd(), rnd());
  endtask

  task automatic fetch(input int low);
    for (int i = 0; i < low; i++) cyc(S1, OP_NONE, 1'b1, C_MRD, 1'b0, 1'b0);
    cyc(S1, OP_NONE, 1'b1, C_MRD | C_IRWR | C_PCWR, 1'b1, 1'b0);
  endtask

  task automatic decode();
    cyc(S2, OP_NONE, 1'b1, C_NONE, rnd(), 1'b0);
  endtask

  task automatic do_alu(input string t, input logic [31:0] ins, input logic [3:0] op, input logic imm);
    set_instr(t, ins);
    fetch(0);
    decode();
    cyc(S5, op, 1'b1, imm ? C_ASRC : C_NONE, rnd(), 1'b0);
    cyc(S6, OP_NONE, 1'b1, C_RW, rnd(), 1'b0);
  endtask

  task automatic do_lw(input int flow, input int mlow);
    set_instr("lw", I_LW);
    fetch(flow);
    decode();
    cyc(S3, OP_ADD, 1'b1, C_ASRC, rnd(), 1'b0);
    for (int i = 0; i < mlow; i++) cyc(S4, OP_NONE, 1'b0, C_MRD, 1'b0, 1'b0);
    cyc(S4, OP_NONE, 1'b0, C_MRD, 1'b1, 1'b0);
    cyc(S6, OP_NONE, 1'b1, C_RW | C_M2R, rnd(), 1'b0);
  endtask

  task automatic do_sw(input int flow);
    set_instr("sw", I_SW);
    fetch(flow);
    decode();
    cyc(S3, OP_ADD, 1'b1, C_ASRC, rnd(), 1'b0);
    cyc(S4, OP_NONE, 1'b0, C_MWR, 1'b1, 1'b0);
  endtask

  task automatic do_beq(input logic z);
    set_instr(z ? "beq_taken" : "beq_not", I_BEQ);
    fetch(0);
    decode();
    cyc(S7, OP_SUB, 1'b1, z ? (C_PCSRC | C_PCWR) : C_NONE, rnd(), z);
  endtask

  task automatic do_trap(input string t, input logic [31:0] ins, input int n);
    set_instr(t, ins);
    fetch(0);
    decode();
    for (int i = 0; i < n; i++) cyc(S8, OP_NONE, 1'b1, C_ILL, rnd(), rnd());
  endtask

  initial begin
    mif_a.instruction = '0; mif_b.instruction = '0;
    mif_a.mem_ready = 1'b0; mif_b.mem_ready = 1'b0;
    mif_a.zero = 1'b0;      mif_b.zero = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    check("cnt_after_reset", 32'(mif_a.instr_count), 32'd0);

    do_alu("add", I_ADD, OP_ADD, 1'b0);
    check("cnt_add", 32'(mif_a.instr_count), 32'd1);
    do_lw(0, 3);
    check("cnt_lw", 32'(mif_a.instr_count), 32'd2);
    do_beq(1'b1);
    do_beq(1'b0);
    check("cnt_beq", 32'(mif_a.instr_count), 32'd4);
    do_alu("sub", I_SUB, OP_SUB, 1'b0);
    do_alu("or", I_OR, OP_OR, 1'b0);
    do_alu("and", I_AND, OP_AND, 1'b0);
    do_alu("addi", I_ADDI, OP_ADD, 1'b1);
    check("cnt_alu", 32'(mif_a.instr_count), 32'd8);
    do_sw(2);
    check("cnt_sw", 32'(mif_a.instr_count), 32'd9);

    // Reset mid-lw: the pending instruction never retires.
    set_instr("lw_abort", I_LW);
    fetch(0);
    decode();
    cyc(S3, OP_ADD, 1'b1, C_ASRC, 1'b1, 1'b0);
    do_reset();
    check("cnt_abort", 32'(mif_a.instr_count), 32'd0);

    do_trap("zero_instr", 32'h0, 20);
    do_reset();
    do_trap("sll_illegal", I_SLL, 3);
    do_reset();

    // Fetch stalls: 15th low cycle traps without a strobe.
    set_instr("fetch_timeout", I_ADD);
    for (int i = 0; i < 14; i++) cyc(S1, OP_NONE, 1'b1, C_MRD, 1'b0, 1'b0);
    cyc(S1, OP_NONE, 1'b1, C_NONE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(S8, OP_NONE, 1'b1, C_ILL, rnd(), 1'b0);
    do_reset();

    // Ready on the limit cycle completes normally.
    set_instr("fetch_limit_ready", I_ADD);
    fetch(14);
    decode();
    cyc(S5, OP_ADD, 1'b1, C_NONE, rnd(), 1'b0);
    cyc(S6, OP_NONE, 1'b1, C_RW, rnd(), 1'b0);
    check("cnt_limit_ready", 32'(mif_a.instr_count), 32'd1);
    do_reset();

    for (int i = 0; i < 15; i++) do_alu("wrap_add", I_ADD, OP_ADD, 1'b0);
    check("cnt_b_15", 32'(mif_b.instr_count), 32'd15);
    do_alu("wrap_add", I_ADD, OP_ADD, 1'b0);
    check("cnt_b_wrap", 32'(mif_b.instr_count), 32'd0);
    check("cnt_a_16", 32'(mif_a.instr_count), 32'd16);

    sel_b = 1'b1;
    do_trap("addi_disabled", I_ADDI, 3);
    do_reset();
    sel_b = 1'b0;

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
